// File: rtl/calc_pkg.sv
// Shared opcodes, FSM state encoding and counter sizing for the calculator
// command sequencer.
package calc_pkg;

  localparam logic [2:0] OP_CLEAR = 3'd0;
  localparam logic [2:0] OP_LOAD  = 3'd1;
  localparam logic [2:0] OP_ADD   = 3'd2;
  localparam logic [2:0] OP_SUB   = 3'd3;
  localparam logic [2:0] OP_MUL   = 3'd4;
  localparam logic [2:0] OP_DIV   = 3'd5;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_PRESS_OP,
    ST_GAP_OP,
    ST_PRESS_EQ,
    ST_GAP_EQ,
    ST_SETTLE,
    ST_RESP
  } state_t;

  // The timer is loaded with (length - 1), so it must hold MAX_CNT - 1.
  function automatic int max_cnt_w(input int hold, input int gap, input int settle);
    int m;
    m = hold;
    if (gap > m) m = gap;
    if (settle > m) m = settle;
    return (m <= 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/calc_phase_timer.sv
// Loadable down-counter shared by every timed phase; done_o marks the last
// cycle of the phase that was loaded with (length - 1).
module calc_phase_timer #(
  parameter int CW = 4
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          load_i,
  input  logic [CW-1:0] load_val_i,
  output logic          done_o
);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/calc_cmd_sequencer.sv
// Drives the FourFuncCalc button interface from opcode/operand commands and
// returns the sampled result on a valid/ready response channel.
module calc_cmd_sequencer
  import calc_pkg::*;
#(
  parameter int W      = 11,
  parameter int HOLD   = 2,
  parameter int GAP    = 2,
  parameter int SETTLE = 16
) (
  input  logic                Clock,
  input  logic                Resetn,
  input  logic                CmdValid,
  output logic                CmdReady,
  input  logic [2:0]          CmdOp,
  input  logic [W-1:0]        CmdNum,
  output logic                RspValid,
  input  logic                RspReady,
  output logic signed [W-1:0] RspResult,
  output logic                RspOverflow,
  output logic                RspErr,
  output logic                CalcClear,
  output logic                CalcEquals,
  output logic                CalcAdd,
  output logic                CalcSub,
  output logic                CalcMul,
  output logic                CalcDiv,
  output logic [W-1:0]        CalcNumber,
  input  logic signed [W-1:0] CalcResult,
  input  logic                CalcOverflow
);

  localparam int CW = max_cnt_w(HOLD, GAP, SETTLE);
  localparam logic [CW-1:0] HOLD_LD   = CW'(HOLD - 1);
  localparam logic [CW-1:0] GAP_LD    = CW'(GAP - 1);
  localparam logic [CW-1:0] SETTLE_LD = CW'(SETTLE - 1);

  state_t                state_q, state_d;
  logic [2:0]            op_q, op_d;
  logic [W-1:0]          num_q, num_d;
  logic                  init_q, init_d;
  logic signed [W-1:0]   res_q, res_d;
  logic                  ovf_q, ovf_d;
  logic                  err_q, err_d;
  logic                  tmr_load;
  logic [CW-1:0]         tmr_val;
  logic                  tmr_done;
  logic                  cmd_reject;
  logic                  press_op;

  calc_phase_timer #(.CW(CW)) u_timer (
    .clk_i      (Clock),
    .rst_n_i    (Resetn),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .done_o     (tmr_done)
  );

  assign cmd_reject = (CmdOp > OP_DIV) ||
                      ((CmdOp == OP_DIV) && (CmdNum[W-2:0] == '0));

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    num_d    = num_q;
    init_d   = init_q;
    res_d    = res_q;
    ovf_d    = ovf_q;
    err_d    = err_q;
    tmr_load = 1'b0;
    tmr_val  = '0;
    unique case (state_q)
      // The power-up clear reuses the CLEAR command path, flagged by init.
      ST_INIT: begin
        state_d  = ST_PRESS_OP;
        op_d     = OP_CLEAR;
        init_d   = 1'b1;
        tmr_load = 1'b1;
        tmr_val  = HOLD_LD;
      end
      ST_IDLE: begin
        if (CmdValid) begin
          op_d  = CmdOp;
          num_d = CmdNum;
          if (cmd_reject) begin
            state_d = ST_RESP;
            err_d   = 1'b1;
            res_d   = '0;
            ovf_d   = 1'b0;
          end else begin
            state_d  = (CmdOp == OP_LOAD) ? ST_PRESS_EQ : ST_PRESS_OP;
            tmr_load = 1'b1;
            tmr_val  = HOLD_LD;
          end
        end
      end
      ST_PRESS_OP: begin
        if (tmr_done) begin
          state_d  = ST_GAP_OP;
          tmr_load = 1'b1;
          tmr_val  = GAP_LD;
        end
      end
      ST_GAP_OP: begin
        if (tmr_done) begin
          if (init_q) begin
            state_d = ST_IDLE;
            init_d  = 1'b0;
          end else if (op_q == OP_CLEAR) begin
            state_d = ST_RESP;
            err_d   = 1'b0;
            res_d   = '0;
            ovf_d   = 1'b0;
          end else begin
            state_d  = ST_PRESS_EQ;
            tmr_load = 1'b1;
            tmr_val  = HOLD_LD;
          end
        end
      end
      ST_PRESS_EQ: begin
        if (tmr_done) begin
          state_d  = ST_GAP_EQ;
          tmr_load = 1'b1;
          tmr_val  = GAP_LD;
        end
      end
      ST_GAP_EQ: begin
        if (tmr_done) begin
          state_d  = ST_SETTLE;
          tmr_load = 1'b1;
          tmr_val  = SETTLE_LD;
        end
      end
      ST_SETTLE: begin
        if (tmr_done) begin
          state_d = ST_RESP;
          err_d   = 1'b0;
          res_d   = CalcResult;
          ovf_d   = CalcOverflow;
        end
      end
      ST_RESP: begin
        if (RspReady) state_d = ST_IDLE;
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state_q <= ST_INIT;
      op_q    <= OP_CLEAR;
      num_q   <= '0;
      init_q  <= 1'b0;
      res_q   <= '0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      num_q   <= num_d;
      init_q  <= init_d;
      res_q   <= res_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
    end
  end

  // Buttons decode from registered state only, so reset forces them low.
  assign press_op    = (state_q == ST_PRESS_OP);
  assign CalcClear   = press_op && (op_q == OP_CLEAR);
  assign CalcAdd     = press_op && (op_q == OP_ADD);
  assign CalcSub     = press_op && (op_q == OP_SUB);
  assign CalcMul     = press_op && (op_q == OP_MUL);
  assign CalcDiv     = press_op && (op_q == OP_DIV);
  assign CalcEquals  = (state_q == ST_PRESS_EQ);
  assign CalcNumber  = num_q;

  assign CmdReady    = (state_q == ST_IDLE);
  assign RspValid    = (state_q == ST_RESP);
  assign RspResult   = res_q;
  assign RspOverflow = ovf_q;
  assign RspErr      = err_q;

endmodule

// File: tb/tb_calc_cmd_sequencer.sv
// Bench for calc_cmd_sequencer: a button-level calculator stand-in plus a
// command-level reference model of the expected responses.
`timescale 1ns/1ps
module tb_calc_cmd_sequencer;

  localparam int W      = 11;
  localparam int HOLD   = 2;
  localparam int GAP    = 2;
  localparam int SETTLE = 16;

  localparam logic [2:0] C_CLEAR = 3'd0;
  localparam logic [2:0] C_LOAD  = 3'd1;
  localparam logic [2:0] C_ADD   = 3'd2;
  localparam logic [2:0] C_SUB   = 3'd3;
  localparam logic [2:0] C_MUL   = 3'd4;
  localparam logic [2:0] C_DIV   = 3'd5;

  logic                Clock = 1'b0;
  logic                Resetn;
  logic                CmdValid;
  logic                CmdReady;
  logic [2:0]          CmdOp;
  logic [W-1:0]        CmdNum;
  logic                RspValid;
  logic                RspReady;
  logic [W-1:0]        RspResult;
  logic                RspOverflow;
  logic                RspErr;
  logic                CalcClear, CalcEquals, CalcAdd, CalcSub, CalcMul, CalcDiv;
  logic [W-1:0]        CalcNumber;
  logic                CalcOverflow;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int ref_acc = 0;

  // Calculator stand-in state
  logic signed [W-1:0] emu_acc  = '0;
  logic                emu_ovf  = 1'b0;
  logic [2:0]          emu_pend = 3'd0;
  logic [5:0]          btn_prev = 6'd0;
  logic [5:0]          btns;
  logic signed [22:0]  emu_raw;
  int                  presses  = 0;
  int                  overlaps = 0;

  calc_cmd_sequencer #(.W(W), .HOLD(HOLD), .GAP(GAP), .SETTLE(SETTLE)) dut (
    .Clock        (Clock),
    .Resetn       (Resetn),
    .CmdValid     (CmdValid),
    .CmdReady     (CmdReady),
    .CmdOp        (CmdOp),
    .CmdNum       (CmdNum),
    .RspValid     (RspValid),
    .RspReady     (RspReady),
    .RspResult    (RspResult),
    .RspOverflow  (RspOverflow),
    .RspErr       (RspErr),
    .CalcClear    (CalcClear),
    .CalcEquals   (CalcEquals),
    .CalcAdd      (CalcAdd),
    .CalcSub      (CalcSub),
    .CalcMul      (CalcMul),
    .CalcDiv      (CalcDiv),
    .CalcNumber   (CalcNumber),
    .CalcResult   (emu_acc),
    .CalcOverflow (emu_ovf)
  );

  always #5 Clock = ~Clock;
  always @(posedge Clock) cyc <= cyc + 1;

  assign btns = {CalcClear, CalcEquals, CalcAdd, CalcSub, CalcMul, CalcDiv};

  function automatic logic signed [22:0] emu_eval(input logic signed [W-1:0] a,
                                                  input logic [2:0] p,
                                                  input logic [W-1:0] v);
    logic signed [22:0] aa, nn;
    aa = a;
    nn = $signed({13'b0, v[W-2:0]});
    if (v[W-1]) nn = -nn;
    case (p)
      3'd0:    return nn;
      3'd1:    return aa + nn;
      3'd2:    return aa - nn;
      3'd3:    return aa * nn;
      default: return (nn == 0) ? 23'sd0 : aa / nn;
    endcase
  endfunction

  assign emu_raw = emu_eval(emu_acc, emu_pend, CalcNumber);

  // Calculator reacts to rising button edges, computing on '='.
  always @(posedge Clock) begin
    btn_prev <= btns;
    if ((btns & ~btn_prev) != 6'd0) presses <= presses + 1;
    if (btns[5] && !btn_prev[5]) begin
      emu_acc  <= '0;
      emu_ovf  <= 1'b0;
      emu_pend <= 3'd0;
    end else if (btns[4] && !btn_prev[4]) begin
      emu_acc  <= emu_raw[W-1:0];
      emu_ovf  <= (emu_raw != {{12{emu_raw[W-1]}}, emu_raw[W-1:0]});
      emu_pend <= 3'd0;
    end else if (btns[3] && !btn_prev[3]) emu_pend <= 3'd1;
    else if (btns[2] && !btn_prev[2]) emu_pend <= 3'd2;
    else if (btns[1] && !btn_prev[1]) emu_pend <= 3'd3;
    else if (btns[0] && !btn_prev[0]) emu_pend <= 3'd4;
  end

  always @(negedge Clock) if ($countones(btns) > 1) overlaps <= overlaps + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int sm2int(input logic [W-1:0] v);
    int m;
    m = int'(v[W-2:0]);
    return v[W-1] ? -m : m;
  endfunction

  function automatic int wrap11(input int r);
    logic signed [W-1:0] s;
    s = r[W-1:0];
    return int'(s);
  endfunction

  function automatic int exp_lat(input logic [2:0] op, input logic rej);
    if (rej) return 1;
    if (op == C_CLEAR) return 1 + HOLD + GAP;
    if (op == C_LOAD) return 1 + HOLD + GAP + SETTLE;
    return 1 + 2*HOLD + 2*GAP + SETTLE;
  endfunction

  task automatic reset_and_check(input int n);
    int clr_cnt, rdy_cyc;
    @(negedge Clock);
    Resetn = 1'b0;
    repeat (n) @(posedge Clock);
    @(negedge Clock);
    chk("rst_buttons", {26'd0, btns}, 32'd0);
    chk("rst_cmdready", CmdReady, 1'b0);
    Resetn = 1'b1;
    clr_cnt = 0;
    rdy_cyc = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge Clock);
      if (k == 1) chk("rst_rsp_zero", {RspValid, RspResult, RspOverflow, RspErr}, 32'd0);
      if (CalcClear) clr_cnt++;
      if (CmdReady && rdy_cyc == 0) rdy_cyc = k;
    end
    chk("init_clear_cycles", clr_cnt, 2);
    chk("init_ready_cycle", rdy_cyc, 1 + HOLD + GAP);
    ref_acc = 0;
  endtask

  task automatic do_cmd(input logic [2:0] op, input logic [W-1:0] num, input int hold);
    int n, r, t, lat, k, p0;
    logic rej, eo;
    logic [W-1:0] er;
    n   = sm2int(num);
    rej = (op > C_DIV) || ((op == C_DIV) && (num[W-2:0] == '0));
    eo  = 1'b0;
    er  = '0;
    r   = 0;
    if (!rej) begin
      case (op)
        C_CLEAR: ref_acc = 0;
        C_LOAD:  ref_acc = n;
        default: begin
          case (op)
            C_ADD:   r = ref_acc + n;
            C_SUB:   r = ref_acc - n;
            C_MUL:   r = ref_acc * n;
            default: r = ref_acc / n;
          endcase
          eo = (r > 1023) || (r < -1024);
          ref_acc = wrap11(r);
        end
      endcase
      er = W'(ref_acc);
    end
    lat = exp_lat(op, rej);
    k = 0;
    @(negedge Clock);
    while (!CmdReady && k < 100) begin
      @(negedge Clock);
      k++;
    end
    chk("cmd_ready", CmdReady, 1'b1);
    p0 = presses;
    CmdValid = 1'b1;
    CmdOp    = op;
    CmdNum   = num;
    RspReady = (hold == 0);
    t = cyc;
    @(negedge Clock);
    CmdValid = 1'b0;
    chk("ready_drop", CmdReady, 1'b0);
    chk("calc_number", CalcNumber, num);
    while (!RspValid && (cyc - t) < 100) @(negedge Clock);
    chk("latency", cyc - t, lat);
    chk("rsp_result", RspResult, er);
    chk("rsp_overflow", RspOverflow, eo);
    chk("rsp_err", RspErr, rej);
    if (rej) chk("reject_no_press", presses - p0, 0);
    if (hold > 0) begin
      CmdValid = 1'b1;
      CmdOp    = C_ADD;
      CmdNum   = 11'h00F;
      for (int i = 0; i < hold; i++) begin
        @(negedge Clock);
        chk("bp_valid", RspValid, 1'b1);
        chk("bp_result", {RspResult, RspOverflow, RspErr}, {er, eo, rej});
        chk("bp_cmdready", CmdReady, 1'b0);
      end
      CmdValid = 1'b0;
      RspReady = 1'b1;
    end
    @(negedge Clock);
    chk("rsp_taken", RspValid, 1'b0);
  endtask

  initial begin
    logic [2:0]   rop;
    logic [W-1:0] rnum;
    int k;
    Resetn   = 1'b0;
    CmdValid = 1'b0;
    CmdOp    = 3'd0;
    CmdNum   = '0;
    RspReady = 1'b1;

    reset_and_check(3);

    do_cmd(C_LOAD, 11'd1, 0);
    do_cmd(C_ADD,  11'd2, 0);
    do_cmd(C_ADD,  11'd3, 0);

    do_cmd(C_LOAD, 11'd5, 0);
    do_cmd(C_SUB,  11'h403, 0);
    do_cmd(C_MUL,  11'd0, 0);

    do_cmd(C_LOAD, 11'h3FF, 0);
    do_cmd(C_ADD,  11'd1, 0);
    do_cmd(C_CLEAR, 11'd0, 0);

    do_cmd(C_DIV,  11'h400, 0);
    do_cmd(3'd7,   11'd5, 0);

    do_cmd(C_LOAD, 11'd7, 10);
    do_cmd(C_DIV,  11'h402, 0);

    // Reset while '=' is being pressed
    k = 0;
    @(negedge Clock);
    while (!CmdReady && k < 100) begin
      @(negedge Clock);
      k++;
    end
    CmdValid = 1'b1;
    CmdOp    = C_ADD;
    CmdNum   = 11'd4;
    @(negedge Clock);
    CmdValid = 1'b0;
    k = 0;
    while (!CalcEquals && k < 50) begin
      @(negedge Clock);
      k++;
    end
    chk("eq_seen", CalcEquals, 1'b1);
    Resetn = 1'b0;
    @(negedge Clock);
    chk("midrst_buttons", {26'd0, btns}, 32'd0);
    chk("midrst_rspvalid", RspValid, 1'b0);
    reset_and_check(2);

    for (int i = 0; i < 40; i++) begin
      rop = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) rnum = W'($urandom_range(0, 2047));
      else rnum = {1'($urandom_range(0, 1)), 10'($urandom_range(0, 15))};
      do_cmd(rop, rnum, $urandom_range(0, 2));
    end

    chk("button_overlap", overlaps, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout tests=%0d", tests);
    $fatal(1, "watchdog");
  end

endmodule
